// File: rtl/jt4701_poll_if.sv
// rtl/jt4701_poll_if.sv - byte-wide bus between the poll sequencer and a uPD4701-style counter
interface jt4701_poll_if;
  logic       q_csn;
  logic       q_uln;
  logic       q_xn_y;
  logic       q_xrst;
  logic       q_yrst;
  logic [7:0] q_din;
  logic       q_cfn;

  modport master (
    output q_csn, q_uln, q_xn_y, q_xrst, q_yrst,
    input  q_din, q_cfn
  );

  modport slave (
    input  q_csn, q_uln, q_xn_y, q_xrst, q_yrst,
    output q_din, q_cfn
  );
endinterface

// File: rtl/jt4701_poll.sv
// rtl/jt4701_poll.sv - polls a trackball counter and turns absolute counts into read-and-clear deltas
module jt4701_poll #(
  parameter int PERIOD = 1024,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rstn,
  jt4701_poll_if.master     q,
  input  logic              cpu_rd,
  input  logic              cpu_sel,
  output logic [7:0]        cpu_dout,
  output logic [2:0]        buttons,
  output logic              busy
);

  localparam int TW = $clog2(PERIOD + SETTLE + 2);

  typedef enum logic [2:0] {INIT, IDLE, XL, XH, YL, YH, CALC} state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   timer, timer_nx;
  logic            sample;
  logic [11:0]     new_x, new_y, last_x, last_y;
  logic [7:0]      acc_x, acc_y;
  logic [11:0]     dx, dy;
  logic [7:0]      base_x, base_y;
  logic [12:0]     sum_x, sum_y;

  function automatic logic [7:0] sat8(input logic signed [12:0] v);
    if (v > 13'sd127)
      return 8'h7F;
    else if (v < -13'sd128)
      return 8'h80;
    else
      return v[7:0];
  endfunction

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    sample   = 1'b0;
    case (state)
      INIT: state_nx = IDLE;
      IDLE: begin
        if (timer == TW'(PERIOD - 1)) begin
          timer_nx = '0;
          if (!q.q_cfn)
            state_nx = XL;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      XL, XH, YL, YH: begin
        if (timer == TW'(SETTLE)) begin
          timer_nx = '0;
          sample   = 1'b1;
          case (state)
            XL:      state_nx = XH;
            XH:      state_nx = YL;
            YL:      state_nx = YH;
            default: state_nx = CALC;
          endcase
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      CALC:    state_nx = IDLE;
      default: state_nx = INIT;
    endcase
  end

  // A read landing on the CALC edge has already taken the old value, so the update starts from zero.
  always_comb begin
    dx     = new_x - last_x;
    dy     = new_y - last_y;
    base_x = (cpu_rd && !cpu_sel) ? 8'h00 : acc_x;
    base_y = (cpu_rd &&  cpu_sel) ? 8'h00 : acc_y;
    sum_x  = {{5{base_x[7]}}, base_x} + {dx[11], dx};
    sum_y  = {{5{base_y[7]}}, base_y} + {dy[11], dy};
  end

  assign q.q_xrst = rstn && (state == INIT);
  assign q.q_yrst = rstn && (state == INIT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= INIT;
      timer    <= '0;
      q.q_csn  <= 1'b1;
      q.q_uln  <= 1'b0;
      q.q_xn_y <= 1'b0;
      busy     <= 1'b0;
      new_x    <= '0;
      new_y    <= '0;
      last_x   <= '0;
      last_y   <= '0;
      acc_x    <= '0;
      acc_y    <= '0;
      cpu_dout <= '0;
      buttons  <= '0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      // Selects follow the next state so they are valid from the first cycle of each state.
      q.q_csn  <= !(state_nx inside {XL, XH, YL, YH});
      q.q_uln  <= (state_nx == XH) || (state_nx == YH);
      q.q_xn_y <= (state_nx == YL) || (state_nx == YH);
      busy     <= state_nx inside {XL, XH, YL, YH, CALC};

      if (sample) begin
        case (state)
          XL: new_x[7:0] <= q.q_din;
          XH: begin
            new_x[11:8] <= q.q_din[3:0];
            buttons     <= ~q.q_din[6:4];
          end
          YL:      new_y[7:0]  <= q.q_din;
          default: new_y[11:8] <= q.q_din[3:0];
        endcase
      end

      if (cpu_rd)
        cpu_dout <= cpu_sel ? acc_y : acc_x;

      if (state == CALC) begin
        acc_x  <= sat8(sum_x);
        acc_y  <= sat8(sum_y);
        last_x <= new_x;
        last_y <= new_y;
      end else if (cpu_rd) begin
        if (cpu_sel)
          acc_y <= '0;
        else
          acc_x <= '0;
      end
    end
  end

endmodule

// File: tb/tb_jt4701_poll.sv
// tb/tb_jt4701_poll.sv - directed bench for jt4701_poll against a registered counter model
module tb_jt4701_poll;
  localparam int PERIOD = 8;
  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cpu_rd;
  logic       cpu_sel;
  logic [7:0] cpu_dout;
  logic [2:0] buttons;
  logic       busy;

  logic [11:0] cnt_x;
  logic [11:0] cnt_y;
  logic [2:0]  btn_n;

  int total = 0;
  int bad   = 0;
  int low_cnt;
  logic [1:0] trace [0:31];

  jt4701_poll_if bus ();

  jt4701_poll #(.PERIOD(PERIOD), .SETTLE(SETTLE)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .q        (bus),
    .cpu_rd   (cpu_rd),
    .cpu_sel  (cpu_sel),
    .cpu_dout (cpu_dout),
    .buttons  (buttons),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Counter model: data output is registered from the select lines.
  always @(posedge clk) begin
    if (bus.q_csn)
      bus.q_din <= 8'hFF;
    else if (bus.q_uln)
      bus.q_din <= {1'b0, btn_n, (bus.q_xn_y ? cnt_y[11:8] : cnt_x[11:8])};
    else
      bus.q_din <= bus.q_xn_y ? cnt_y[7:0] : cnt_x[7:0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(output int xr, output int yr);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    xr = int'(bus.q_xrst);
    yr = int'(bus.q_yrst);
    repeat (5) begin
      @(negedge clk);
      xr += int'(bus.q_xrst);
      yr += int'(bus.q_yrst);
    end
  endtask

  task automatic wait_busy(input logic lvl, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (busy == lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_poll(input logic [11:0] x, input logic [11:0] y);
    bit ok;
    cnt_x = x;
    cnt_y = y;
    bus.q_cfn = 1'b0;
    low_cnt = 0;
    wait_busy(1'b1, 4 * PERIOD + 10, ok);
    check("poll_start", 32'(ok), 32'd1);
    bus.q_cfn = 1'b1;
    for (int i = 0; i < 40 && busy; i++) begin
      if (!bus.q_csn) begin
        trace[low_cnt[4:0]] = {bus.q_xn_y, bus.q_uln};
        low_cnt++;
      end
      @(negedge clk);
    end
    check("poll_end", 32'(busy), 32'd0);
  endtask

  task automatic rd(input logic sel, output logic [7:0] v);
    @(negedge clk);
    cpu_rd  = 1'b1;
    cpu_sel = sel;
    @(negedge clk);
    cpu_rd  = 1'b0;
    v = cpu_dout;
  endtask

  initial begin
    logic [7:0] v;
    int xr, yr, viol;
    bit ok;

    rstn = 1'b0;
    cpu_rd = 1'b0;
    cpu_sel = 1'b0;
    cnt_x = '0;
    cnt_y = '0;
    btn_n = 3'b111;
    bus.q_cfn = 1'b1;

    // reset and init pulse
    repeat (3) @(negedge clk);
    check("rst_csn", 32'(bus.q_csn), 32'd1);
    check("rst_dout", 32'(cpu_dout), 32'd0);
    check("rst_xrst", 32'(bus.q_xrst), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    do_reset(xr, yr);
    check("init_xrst_cycles", 32'(xr), 32'd1);
    check("init_yrst_cycles", 32'(yr), 32'd1);
    check("init_busy", 32'(busy), 32'd0);

    // basic poll
    do_poll(12'h005, 12'hFFE);
    check("poll_low_cycles", 32'(low_cnt), 32'd12);
    check("order_xl", 32'(trace[0]), 32'd0);
    check("order_xh", 32'(trace[3]), 32'd1);
    check("order_yl", 32'(trace[6]), 32'd2);
    check("order_yh", 32'(trace[9]), 32'd3);
    rd(1'b0, v); check("basic_x", 32'(v), 32'h05);
    rd(1'b1, v); check("basic_y", 32'(v), 32'hFE);
    rd(1'b0, v); check("basic_x_clear", 32'(v), 32'h00);

    // saturation
    do_reset(xr, yr);
    do_poll(12'h300, 12'h000);
    rd(1'b0, v); check("sat_pos_x", 32'(v), 32'h7F);
    rd(1'b1, v); check("sat_y_zero", 32'(v), 32'h00);
    do_poll(12'h310, 12'h000);
    rd(1'b0, v); check("after_sat_x", 32'(v), 32'h10);

    // wrap-around
    do_poll(12'hFFD, 12'h000);
    rd(1'b0, v); check("sat_neg_x", 32'(v), 32'h80);
    do_poll(12'h002, 12'h000);
    rd(1'b0, v); check("wrap_up_x", 32'(v), 32'h05);
    do_poll(12'hFFD, 12'h000);
    rd(1'b0, v); check("wrap_down_x", 32'(v), 32'hFB);

    // idle skip and buttons
    check("buttons_idle", 32'(buttons), 32'd0);
    bus.q_cfn = 1'b1;
    viol = 0;
    repeat (3 * PERIOD + 5) begin
      @(negedge clk);
      if (!bus.q_csn || busy) viol++;
    end
    check("idle_skip", 32'(viol), 32'd0);
    btn_n = 3'b010;
    do_poll(12'h001, 12'h000);
    check("buttons", 32'(buttons), 32'b101);

    // read coincident with CALC: X accumulator holds 4, d = +2
    cnt_x = 12'h003;
    bus.q_cfn = 1'b0;
    wait_busy(1'b1, 4 * PERIOD + 10, ok);
    check("coll_start", 32'(ok), 32'd1);
    bus.q_cfn = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (busy && bus.q_csn) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("coll_calc_found", 32'(ok), 32'd1);
    cpu_rd = 1'b1;
    cpu_sel = 1'b0;
    @(negedge clk);
    cpu_rd = 1'b0;
    check("coll_dout", 32'(cpu_dout), 32'h04);
    rd(1'b0, v); check("coll_next_x", 32'(v), 32'h02);

    // reset in the middle of YL
    do_poll(12'h006, 12'h000);
    cnt_x = 12'h00A;
    bus.q_cfn = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 4 * PERIOD + 20; i++) begin
      @(negedge clk);
      if (!bus.q_csn && bus.q_xn_y && !bus.q_uln) begin
        ok = 1'b1;
        break;
      end
    end
    check("yl_found", 32'(ok), 32'd1);
    bus.q_cfn = 1'b1;
    rstn = 1'b0;
    #1;
    check("abort_csn", 32'(bus.q_csn), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_xn_y", 32'(bus.q_xn_y), 32'd0);
    do_reset(xr, yr);
    rd(1'b0, v); check("abort_acc_x", 32'(v), 32'h00);
    rd(1'b1, v); check("abort_acc_y", 32'(v), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/jt4701_poll.md
Name: jt4701_poll

Overview:
- Sequencer that periodically reads a uPD4701-compatible trackball counter over its byte-wide bus (chip select, byte select, axis select).
- Converts successive 12-bit absolute counts into saturating signed 8-bit motion deltas per axis.
- Presents the deltas and button states to the game CPU through a read-and-clear port.
- Sits between the trackball counter instance and the CPU input-port decoder, so the CPU never drives the counter bus directly.

Parameters:
- PERIOD, 1024: clk cycles spent in IDLE between poll attempts; must be ≥ 1.
- SETTLE, 2: extra cycles each select combination is held before `q_din` is sampled; must be ≥ 1, because the counter's data output is registered.

Ports:
- clk, input, 1: system clock.
- rstn, input, 1: asynchronous active-low reset.
- q_csn, output, 1: counter chip select, active low.
- q_uln, output, 1: counter byte select; 1 = upper byte.
- q_xn_y, output, 1: counter axis select; 1 = Y.
- q_xrst, output, 1: counter X reset, active high.
- q_yrst, output, 1: counter Y reset, active high.
- q_din, input, 8: counter data output.
- q_cfn, input, 1: counter flag, active low; low means motion is pending.
- cpu_rd, input, 1: read strobe, one cycle per read.
- cpu_sel, input, 1: axis for the read; 0 = X, 1 = Y.
- cpu_dout, output, 8: signed delta for the selected axis.
- buttons, output, 3: {left, right, middle}, active high.
- busy, output, 1: high while a poll sequence is in progress.

Behaviour:
- **Reset (async, rstn low):**
  - FSM = INIT; q_csn = 1, q_uln = 0, q_xn_y = 0, q_xrst = q_yrst = 0.
  - Accumulators, last-count registers, timer, cpu_dout, buttons and busy all = 0.
  - Reset asserted mid-poll aborts the poll; no partial update survives.
- **INIT:**
  - One cycle with q_xrst = q_yrst = 1, then go to IDLE.
  - The last-count registers stay 0 and match the zeroed counter.
- **IDLE:**
  - q_csn = 1, busy = 0; timer counts 0 to PERIOD-1.
  - At terminal count the timer clears. If q_cfn = 0, go to XL. If q_cfn = 1, stay in IDLE and restart the period.
- **Poll states** XL, XH, YL, YH, each held for SETTLE+1 cycles:
  - q_csn = 0 throughout; busy = 1.
  - XL: q_xn_y = 0, q_uln = 0. XH: q_xn_y = 0, q_uln = 1. YL: q_xn_y = 1, q_uln = 0. YH: q_xn_y = 1, q_uln = 1.
  - Select lines change on state entry. q_din is captured on the last cycle of each state.
  - XL/YL capture count bits [7:0]. XH/YH capture count bits [11:8] from q_din[3:0].
  - XH also captures buttons = ~q_din[6:4].
  - After YH, go to CALC.
- **CALC** (1 cycle, q_csn = 1, busy = 1):
  - For each axis: d = (new − last) mod 4096, interpreted as signed 12-bit (−2048..2047).
  - acc = sat8(acc + d), clamped to −128..127. last ← new.
  - Then go to IDLE.
  - Poll latency from leaving IDLE to accumulator update = 4·(SETTLE+1)+1 cycles.
- **Counter wrap:** 4095 → 2 gives d = +3. 2 → 4095 gives d = −3.
- **CPU read:**
  - On cpu_rd, cpu_dout ← acc[cpu_sel] on the next clock edge (1-cycle latency), and acc[cpu_sel] clears on the same edge.
  - cpu_dout holds its value until the next cpu_rd.
  - The other axis is unaffected.
- **cpu_rd coincident with CALC on the same axis:** cpu_dout gets the pre-CALC accumulator value. The accumulator becomes sat8(0 + d), so no motion is lost or double-counted.
- **cpu_rd outside CALC:** allowed in any state.
- **Other rules:**
  - buttons updates only in XH.
  - q_xrst/q_yrst are asserted only in INIT.

Test Plan:
1. **Reset/init:** rstn low then high. Expect:
   - q_csn = 1 and cpu_dout = 0 during reset.
   - Exactly one cycle of q_xrst = q_yrst = 1 after release.
   - busy = 0.
2. **Basic poll:** model counter X = 0x005, Y = 0xFFE, q_cfn = 0, SETTLE = 2. Expect:
   - State order XL, XH, YL, YH, with q_csn low for 12 cycles.
   - After CALC, reading X gives 0x05 and reading Y gives 0xFE.
   - A second read of X gives 0x00.
3. **Saturation:** X count goes 0 → 0x300. Expect:
   - Read X = 0x7F; last = 0x300.
   - X then goes to 0x310: read X = 0x10.
4. **Wrap-around:** X goes 0xFFD → 0x002. Expect read X = 0x05. Reverse direction (0x002 → 0xFFD) gives 0xFB.
5. **Idle skip and buttons:** q_cfn = 1 across three periods. Expect q_csn to stay high and busy = 0. Then q_cfn = 0 with q_din[6:4] = 3'b010 in XH: expect buttons = 3'b101.
6. **Read/update collision:** X accumulator = 0x04 and cpu_rd with cpu_sel = 0 in the CALC cycle with d = +2. Expect cpu_dout = 0x04; the next read X = 0x02. Also assert rstn low during YL: expect immediate q_csn = 1 and accumulators = 0.
